cci_mpf_shim_rd_tracker: RTL

- Non-intrusive monitor on the FIU side of the response-ordering shim.
- Watches c0 read requests, after Mdata has been replaced by the allocated index, and the raw FIU read responses.
- Tracks every in-flight line slot and per-request beat counts; flags protocol violations: duplicate index allocation, unexpected or duplicate response beats.
- Exports active line and request counts for almost-full debug and perf counters. Traffic is not modified.

---
 rtl/cci_mpf_shim_rd_tracker.sv | 99 +++++++++
 1 files changed

// File: rtl/cci_mpf_shim_rd_tracker.sv
// Passive read-traffic tracker: per-slot occupancy and per-request beat counts, with sticky protocol errors.
// All outputs are registered and update one cycle after an event. It never applies backpressure.
module cci_mpf_shim_rd_tracker #(
  parameter int MAX_ACTIVE_REQS = 128
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                tx_rd_valid,
  input  logic [$clog2(MAX_ACTIVE_REQS)-1:0]  tx_rd_idx,
  input  logic [1:0]                          tx_rd_cl_len,
  input  logic                                rx_rd_valid,
  input  logic [$clog2(MAX_ACTIVE_REQS)-1:0]  rx_rd_idx,
  input  logic [1:0]                          rx_rd_cl_num,
  input  logic                                clear_errors,
  output logic [$clog2(MAX_ACTIVE_REQS):0]    lines_active,
  output logic [$clog2(MAX_ACTIVE_REQS):0]    reqs_active,
  output logic                                err_dup_alloc,
  output logic                                err_unexpected_rsp,
  output logic                                err_valid,
  output logic [$clog2(MAX_ACTIVE_REQS)-1:0]  err_idx
);

  localparam int N_IDX = $clog2(MAX_ACTIVE_REQS);

  logic [MAX_ACTIVE_REQS-1:0] slot_active;
  logic [2:0]                 remaining [MAX_ACTIVE_REQS];

  logic [MAX_ACTIVE_REQS-1:0] tx_mask;
  logic [MAX_ACTIVE_REQS-1:0] rx_mask;
  logic [MAX_ACTIVE_REQS-1:0] slot_next;
  logic                       tx_ok, tx_err, rx_ok, rx_err;
  logic [N_IDX-1:0]           rx_slot;
  logic [2:0]                 rx_rem;
  logic [2:0]                 tx_beats;
  logic [N_IDX:0]             lines_next, reqs_next;
  logic                       dup_next, unexp_next, valid_next;
  logic [N_IDX-1:0]           idx_next;

  // Slot indices are N_IDX bits wide, so the additions wrap modulo MAX_ACTIVE_REQS for free.
  always_comb begin
    tx_mask = '0;
    for (int k = 0; k < 4; k++) begin
      if (2'(k) <= tx_rd_cl_len) tx_mask[tx_rd_idx + N_IDX'(k)] = 1'b1;
    end
    tx_beats = {1'b0, tx_rd_cl_len} + 3'd1;
    tx_ok    = tx_rd_valid && ((tx_mask & slot_active) == '0);
    tx_err   = tx_rd_valid && !tx_ok;

    rx_slot  = rx_rd_idx + N_IDX'(rx_rd_cl_num);
    rx_rem   = remaining[rx_rd_idx];
    rx_ok    = rx_rd_valid && slot_active[rx_slot] && (rx_rem != 3'd0);
    rx_err   = rx_rd_valid && !rx_ok;
    rx_mask  = '0;
    rx_mask[rx_slot] = rx_ok;

    slot_next  = (slot_active | (tx_ok ? tx_mask : '0)) & ~rx_mask;
    lines_next = lines_active + (tx_ok ? (N_IDX+1)'(tx_beats) : '0)
                              - (rx_ok ? (N_IDX+1)'(1) : '0);
    reqs_next  = reqs_active + (tx_ok ? (N_IDX+1)'(1) : '0)
                             - ((rx_ok && rx_rem == 3'd1) ? (N_IDX+1)'(1) : '0);
  end

  // A clear in the same cycle as a new error yields the new error, freshly captured.
  always_comb begin
    dup_next   = (err_dup_alloc && !clear_errors) || tx_err;
    unexp_next = (err_unexpected_rsp && !clear_errors) || rx_err;
    valid_next = (err_valid && !clear_errors) || tx_err || rx_err;
    idx_next   = clear_errors ? '0 : err_idx;
    if (!err_valid || clear_errors) begin
      if (tx_err)      idx_next = tx_rd_idx;
      else if (rx_err) idx_next = rx_slot;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_active        <= '0;
      for (int i = 0; i < MAX_ACTIVE_REQS; i++) remaining[i] <= 3'd0;
      lines_active       <= '0;
      reqs_active        <= '0;
      err_dup_alloc      <= 1'b0;
      err_unexpected_rsp <= 1'b0;
      err_valid          <= 1'b0;
      err_idx            <= '0;
    end else begin
      slot_active <= slot_next;
      if (rx_ok) remaining[rx_rd_idx] <= rx_rem - 3'd1;
      // Base of a new request overrides a same-cycle decrement of a stale count.
      if (tx_ok) remaining[tx_rd_idx] <= tx_beats;
      lines_active       <= lines_next;
      reqs_active        <= reqs_next;
      err_dup_alloc      <= dup_next;
      err_unexpected_rsp <= unexp_next;
      err_valid          <= valid_next;
      err_idx            <= idx_next;
    end
  end

endmodule
